// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU among NREQ requesters.
// Each winning op's result is registered into a one-deep response slot owned by that winner.
module alu_arbiter #(
   parameter int NREQ = 2,
   parameter int DW   = 32,
   parameter int OPW  = 4
) (
   input  logic                CLK,
   input  logic                nRST,
   input  logic [NREQ-1:0]     req_valid,
   output logic [NREQ-1:0]     req_ready,
   input  logic [NREQ*OPW-1:0] req_aluop,
   input  logic [NREQ*DW-1:0]  req_porta,
   input  logic [NREQ*DW-1:0]  req_portb,
   output logic [NREQ-1:0]     rsp_valid,
   input  logic [NREQ-1:0]     rsp_ready,
   output logic [DW-1:0]       rsp_out,
   output logic                rsp_negative,
   output logic                rsp_zero,
   output logic                rsp_overflow,
   output logic [OPW-1:0]      alu_aluop,
   output logic [DW-1:0]       alu_porta,
   output logic [DW-1:0]       alu_portb,
   input  logic [DW-1:0]       alu_outport,
   input  logic                alu_negative,
   input  logic                alu_zero,
   input  logic                alu_overflow
);

   localparam int IW = (NREQ > 2) ? 2 : 1;
   localparam logic [OPW-1:0] ALU_ADD = OPW'(2);

   typedef enum logic {IDLE, HOLD} state_t;

   state_t          state_q, state_d;
   logic [IW-1:0]   ptr_q, ptr_d;
   logic [IW-1:0]   own_q, own_d;
   logic [DW-1:0]   out_q, out_d;
   logic            neg_q, neg_d;
   logic            zero_q, zero_d;
   logic            ovf_q, ovf_d;

   logic            pop;
   logic            can_accept;
   logic            found;
   logic            grant;
   logic [IW-1:0]   win;

   // First valid requester at or after ptr, wrapping.
   always_comb begin
      found = 1'b0;
      win   = '0;
      for (int k = 0; k < NREQ; k++) begin
         if (!found && req_valid[(int'(ptr_q) + k) % NREQ]) begin
            found = 1'b1;
            win   = IW'((int'(ptr_q) + k) % NREQ);
         end
      end
   end

   always_comb begin
      pop        = (state_q == HOLD) && rsp_ready[own_q];
      can_accept = (state_q == IDLE) || pop;
      grant      = can_accept && found && nRST;

      req_ready = '0;
      alu_aluop = ALU_ADD;
      alu_porta = '0;
      alu_portb = '0;
      if (grant) begin
         req_ready[win] = 1'b1;
         alu_aluop      = req_aluop[int'(win)*OPW +: OPW];
         alu_porta      = req_porta[int'(win)*DW +: DW];
         alu_portb      = req_portb[int'(win)*DW +: DW];
      end

      rsp_valid = '0;
      if (state_q == HOLD) rsp_valid[own_q] = 1'b1;
   end

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      own_d   = own_q;
      out_d   = out_q;
      neg_d   = neg_q;
      zero_d  = zero_q;
      ovf_d   = ovf_q;
      if (grant) begin
         state_d = HOLD;
         own_d   = win;
         ptr_d   = IW'((int'(win) + 1) % NREQ);
         out_d   = alu_outport;
         neg_d   = alu_negative;
         zero_d  = alu_zero;
         ovf_d   = alu_overflow;
      end else if (pop) begin
         state_d = IDLE;
      end
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         own_q   <= '0;
         out_q   <= '0;
         neg_q   <= 1'b0;
         zero_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         own_q   <= own_d;
         out_q   <= out_d;
         neg_q   <= neg_d;
         zero_q  <= zero_d;
         ovf_q   <= ovf_d;
      end
   end

   assign rsp_out      = out_q;
   assign rsp_negative = neg_q;
   assign rsp_zero     = zero_q;
   assign rsp_overflow = ovf_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a small behavioural ALU on the shared port.
// Expected values are hand-computed constants.
module tb_alu_arbiter;

   localparam int NREQ = 2;
   localparam int DW   = 32;
   localparam int OPW  = 4;
   localparam logic [OPW-1:0] OP_ADD = 4'd2;
   localparam logic [OPW-1:0] OP_SUB = 4'd3;

   logic                CLK = 1'b0;
   logic                nRST;
   logic [NREQ-1:0]     req_valid;
   logic [NREQ-1:0]     req_ready;
   logic [NREQ*OPW-1:0] req_aluop;
   logic [NREQ*DW-1:0]  req_porta;
   logic [NREQ*DW-1:0]  req_portb;
   logic [NREQ-1:0]     rsp_valid;
   logic [NREQ-1:0]     rsp_ready;
   logic [DW-1:0]       rsp_out;
   logic                rsp_negative;
   logic                rsp_zero;
   logic                rsp_overflow;
   logic [OPW-1:0]      alu_aluop;
   logic [DW-1:0]       alu_porta;
   logic [DW-1:0]       alu_portb;
   logic [DW-1:0]       alu_outport;
   logic                alu_negative;
   logic                alu_zero;
   logic                alu_overflow;

   int checks = 0;
   int failures = 0;

   alu_arbiter #(.NREQ(NREQ), .DW(DW), .OPW(OPW)) dut (
      .CLK(CLK), .nRST(nRST),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_aluop(req_aluop), .req_porta(req_porta), .req_portb(req_portb),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_out(rsp_out),
      .rsp_negative(rsp_negative), .rsp_zero(rsp_zero),
      .rsp_overflow(rsp_overflow),
      .alu_aluop(alu_aluop), .alu_porta(alu_porta), .alu_portb(alu_portb),
      .alu_outport(alu_outport), .alu_negative(alu_negative),
      .alu_zero(alu_zero), .alu_overflow(alu_overflow)
   );

   always #5 CLK = ~CLK;

   // Reference ALU: ADD/SUB with signed overflow, AND otherwise.
   always_comb begin
      alu_outport  = alu_porta & alu_portb;
      alu_overflow = 1'b0;
      if (alu_aluop == OP_ADD) begin
         alu_outport  = alu_porta + alu_portb;
         alu_overflow = (alu_porta[31] == alu_portb[31]) &&
                        (alu_outport[31] != alu_porta[31]);
      end else if (alu_aluop == OP_SUB) begin
         alu_outport  = alu_porta - alu_portb;
         alu_overflow = (alu_porta[31] != alu_portb[31]) &&
                        (alu_outport[31] != alu_porta[31]);
      end
      alu_negative = alu_outport[31];
      alu_zero     = (alu_outport == '0);
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic set_req(input int i, input logic [OPW-1:0] op,
                          input logic [DW-1:0] a, input logic [DW-1:0] b);
      req_aluop[i*OPW +: OPW] = op;
      req_porta[i*DW +: DW]   = a;
      req_portb[i*DW +: DW]   = b;
   endtask

   initial begin
      nRST      = 1'b0;
      req_valid = 2'b01;
      rsp_ready = 2'b00;
      req_aluop = '0;
      req_porta = '0;
      req_portb = '0;
      #12;
      chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
      chk("rst_rsp_out", rsp_out, 32'h0);
      chk("rst_req_ready", 32'(req_ready), 32'h0);
      chk("rst_flags", {29'b0, rsp_negative, rsp_zero, rsp_overflow}, 32'h0);
      req_valid = 2'b00;
      #1 nRST = 1'b1;
      tick();

      // 1: single ADD 5+7
      set_req(0, OP_ADD, 32'd5, 32'd7);
      req_valid = 2'b01;
      rsp_ready = 2'b01;
      #1;
      chk("t1_req_ready", 32'(req_ready), 32'h1);
      chk("t1_alu_porta", alu_porta, 32'd5);
      tick();
      chk("t1_rsp_valid", 32'(rsp_valid), 32'h1);
      chk("t1_rsp_out", rsp_out, 32'd12);
      chk("t1_zero", 32'(rsp_zero), 32'h0);
      req_valid = 2'b00;
      #1;
      chk("idle_alu_op", 32'(alu_aluop), 32'(OP_ADD));
      chk("idle_alu_porta", alu_porta, 32'h0);
      tick();
      chk("t1_drain", 32'(rsp_valid), 32'h0);

      // 2: back-to-back alternation, ptr is 1 here
      set_req(0, OP_ADD, 32'd1, 32'd1);
      set_req(1, OP_SUB, 32'd10, 32'd3);
      req_valid = 2'b11;
      rsp_ready = 2'b11;
      for (int n = 0; n < 4; n++) begin
         #1;
         chk("t2_req_ready", 32'(req_ready), (n % 2 == 0) ? 32'h2 : 32'h1);
         tick();
         chk("t2_rsp_valid", 32'(rsp_valid), (n % 2 == 0) ? 32'h2 : 32'h1);
         chk("t2_rsp_out", rsp_out, (n % 2 == 0) ? 32'd7 : 32'd2);
      end
      req_valid = 2'b00;
      tick();
      chk("t2_drain", 32'(rsp_valid), 32'h0);

      // 3: backpressure on owner 0 while req1 waits
      set_req(0, OP_ADD, 32'd20, 32'd22);
      set_req(1, OP_ADD, 32'd100, 32'd1);
      req_valid = 2'b01;
      rsp_ready = 2'b00;
      #1;
      chk("t3_req_ready0", 32'(req_ready), 32'h1);
      tick();
      chk("t3_rsp_out0", rsp_out, 32'd42);
      req_valid = 2'b10;
      rsp_ready = 2'b10;
      for (int n = 0; n < 3; n++) begin
         #1;
         chk("t3_stall_ready", 32'(req_ready), 32'h0);
         tick();
         chk("t3_stall_out", rsp_out, 32'd42);
         chk("t3_stall_valid", 32'(rsp_valid), 32'h1);
      end
      rsp_ready = 2'b01;
      #1;
      chk("t3_pop_grant", 32'(req_ready), 32'h2);
      tick();
      chk("t3_rsp_valid1", 32'(rsp_valid), 32'h2);
      chk("t3_rsp_out1", rsp_out, 32'd101);
      req_valid = 2'b00;
      rsp_ready = 2'b11;
      tick();

      // 4: overflow/negative then zero, pop+grant same cycle
      set_req(0, OP_ADD, 32'h7FFF_FFFF, 32'd1);
      req_valid = 2'b01;
      rsp_ready = 2'b01;
      #1;
      chk("t4_req_ready", 32'(req_ready), 32'h1);
      tick();
      chk("t4_out", rsp_out, 32'h8000_0000);
      chk("t4_ovf", 32'(rsp_overflow), 32'h1);
      chk("t4_neg", 32'(rsp_negative), 32'h1);
      chk("t4_zero", 32'(rsp_zero), 32'h0);
      set_req(0, OP_SUB, 32'd3, 32'd3);
      #1;
      chk("t4_pop_grant", 32'(req_ready), 32'h1);
      tick();
      chk("t4_sub_valid", 32'(rsp_valid), 32'h1);
      chk("t4_sub_zero", 32'(rsp_zero), 32'h1);
      chk("t4_sub_out", rsp_out, 32'h0);
      chk("t4_sub_ovf", 32'(rsp_overflow), 32'h0);
      chk("t4_sub_neg", 32'(rsp_negative), 32'h0);

      // 6: async reset while HOLD
      set_req(0, OP_ADD, 32'd1, 32'd2);
      rsp_ready = 2'b00;
      tick();
      chk("t6_hold", 32'(rsp_valid), 32'h1);
      #2 nRST = 1'b0;
      #1;
      chk("t6_rst_valid", 32'(rsp_valid), 32'h0);
      chk("t6_rst_out", rsp_out, 32'h0);
      chk("t6_rst_ready", 32'(req_ready), 32'h0);
      nRST = 1'b1;
      set_req(0, OP_ADD, 32'd1, 32'd1);
      set_req(1, OP_ADD, 32'd9, 32'd9);
      req_valid = 2'b11;
      rsp_ready = 2'b11;
      #1;
      chk("t6_first", 32'(req_ready), 32'h1);
      tick();
      chk("t6_out0", rsp_out, 32'd2);
      #1;
      chk("t6_second", 32'(req_ready), 32'h2);
      tick();
      chk("t6_out1", rsp_out, 32'd18);

      // 5: only req1 valid with ptr 0, ptr wraps back to 0
      req_valid = 2'b10;
      #1;
      chk("t5_skip", 32'(req_ready), 32'h2);
      tick();
      chk("t5_valid", 32'(rsp_valid), 32'h2);
      req_valid = 2'b11;
      #1;
      chk("t5_ptr_wrap", 32'(req_ready), 32'h1);
      tick();
      req_valid = 2'b00;
      tick();
      chk("end_idle", 32'(rsp_valid), 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
